// File: rtl/arb2_mux_sel.sv
// arb2_mux_sel: two-source round-robin sequencer that sits in front of a
// 2:1 select mux. Each source gets a one-word buffer that drives the mux
// data input directly. A registered select code steers the mux for exactly
// one cycle per grant. The mux result is captured into a valid/ready output
// register.
module arb2_mux_sel #(
  parameter int n = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [n-1:0] in0_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  input  logic [n-1:0] in1_data,
  output logic [n-1:0] d0,
  output logic [n-1:0] d1,
  output logic [1:0]   sel,
  input  logic [n-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [n-1:0] out_data,
  output logic         out_src,
  output logic [7:0]   cnt0,
  output logic [7:0]   cnt1
);

  // Select code that makes the downstream mux output zero.
  localparam logic [1:0] SEL_IDLE = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t       r_state;
  state_t       w_state_next;
  logic [1:0]   r_sel;
  logic [1:0]   w_sel_next;
  logic         r_g;
  logic         w_g_next;
  logic         r_last;
  logic         w_last_next;
  logic         r_out_valid;
  logic         w_out_valid_next;
  logic         w_capture;
  logic [n-1:0] r_out_data;
  logic         r_out_src;

  // Per-source views, indexed by source number.
  logic [1:0]   w_in_valid;
  logic [n-1:0] w_in_data [2];
  logic [1:0]   w_full;
  logic [1:0]   w_accept;
  logic [1:0]   w_done;
  logic [n-1:0] w_data [2];
  logic [7:0]   w_cnt [2];

  // Arbitration result.
  logic         w_grant_valid;
  logic         w_grant_src;

  assign w_in_valid   = {in1_valid, in0_valid};
  assign w_in_data[0] = in0_data;
  assign w_in_data[1] = in1_data;

  // A grant completes at the closing edge of SEL. That single event releases
  // the buffer and bumps the grant counter of the granted source.
  assign w_done[0] = (r_state == SEL) && (r_g == 1'b0);
  assign w_done[1] = (r_state == SEL) && (r_g == 1'b1);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic         r_full;
      logic [n-1:0] r_data;
      logic [7:0]   r_cnt;

      // Ready is the inverse of the buffer flag, so a released buffer can only
      // accept again on the edge after the release.
      assign w_accept[gi] = w_in_valid[gi] & ~r_full;
      assign w_full[gi]   = r_full;
      assign w_data[gi]   = r_data;
      assign w_cnt[gi]    = r_cnt;

      // Buffer occupancy: set on accept, cleared when the grant completes.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_full <= 1'b0;
        end else if (w_accept[gi]) begin
          r_full <= 1'b1;
        end else if (w_done[gi]) begin
          r_full <= 1'b0;
        end
      end

      // Buffered word: loads on accept and holds after release, so the mux
      // input only changes when new data arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_data <= '0;
        end else if (w_accept[gi]) begin
          r_data <= w_in_data[gi];
        end
      end

      // Grant counter, saturating at 255.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt <= 8'd0;
        end else if (w_done[gi] && (r_cnt != 8'hFF)) begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
    end
  endgenerate

  // Round robin: a lone full buffer wins outright. On a tie the source that
  // was not granted last wins.
  always_comb begin
    w_grant_valid = |w_full;
    if (&w_full) begin
      w_grant_src = ~r_last;
    end else begin
      w_grant_src = w_full[1];
    end
  end

  // Next-state and registered-output decode for the sequencing FSM.
  always_comb begin
    w_state_next     = r_state;
    w_sel_next       = r_sel;
    w_g_next         = r_g;
    w_last_next      = r_last;
    w_out_valid_next = r_out_valid;
    w_capture        = 1'b0;
    case (r_state)
      IDLE: begin
        w_sel_next = SEL_IDLE;
        if (w_grant_valid) begin
          w_sel_next   = {1'b0, w_grant_src};
          w_g_next     = w_grant_src;
          w_state_next = SEL;
        end
      end
      SEL: begin
        // The mux has settled on y during this cycle; capture it now.
        w_capture        = 1'b1;
        w_out_valid_next = 1'b1;
        w_last_next      = r_g;
        w_sel_next       = SEL_IDLE;
        w_state_next     = HOLD;
      end
      HOLD: begin
        w_sel_next = SEL_IDLE;
        if (out_ready) begin
          w_out_valid_next = 1'b0;
          if (w_grant_valid) begin
            // Back-to-back path: skip IDLE when another word is waiting.
            w_sel_next   = {1'b0, w_grant_src};
            w_g_next     = w_grant_src;
            w_state_next = SEL;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_sel_next       = SEL_IDLE;
        w_out_valid_next = 1'b0;
        w_state_next     = IDLE;
      end
    endcase
  end

  // FSM state, select code and arbitration history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sel       <= SEL_IDLE;
      r_g         <= 1'b0;
      r_last      <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_sel       <= w_sel_next;
      r_g         <= w_g_next;
      r_last      <= w_last_next;
      r_out_valid <= w_out_valid_next;
    end
  end

  // Result register: holds the captured mux output and its source.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_data <= '0;
      r_out_src  <= 1'b0;
    end else if (w_capture) begin
      r_out_data <= y;
      r_out_src  <= r_g;
    end
  end

  assign in0_ready = ~w_full[0];
  assign in1_ready = ~w_full[1];
  assign d0        = w_data[0];
  assign d1        = w_data[1];
  assign sel       = r_sel;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_src   = r_out_src;
  assign cnt0      = w_cnt[0];
  assign cnt1      = w_cnt[1];

endmodule

// File: tb/tb_arb2_mux_sel.sv
// Testbench for arb2_mux_sel. It models the downstream 2:1 mux. Expected
// results go into a scoreboard queue when stimulus is issued. A monitor pops
// and compares on every output handshake. Direct checks cover the select
// sequence, ready flags and counters.
module tb_arb2_mux_sel;
  localparam int N = 2;

  logic         clk;
  logic         rst_n;
  logic         in0_valid;
  logic         in0_ready;
  logic [N-1:0] in0_data;
  logic         in1_valid;
  logic         in1_ready;
  logic [N-1:0] in1_data;
  logic [N-1:0] d0;
  logic [N-1:0] d1;
  logic [1:0]   sel;
  logic [N-1:0] y;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_src;
  logic [7:0]   cnt0;
  logic [7:0]   cnt1;

  int tests = 0;
  int fails = 0;

  // Scoreboard entries are {src, data}.
  logic [N:0] exp_q[$];
  logic [N:0] mon_exp;

  arb2_mux_sel #(.n(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_ready(in0_ready),
    .in0_data (in0_data),
    .in1_valid(in1_valid),
    .in1_ready(in1_ready),
    .in1_data (in1_data),
    .d0       (d0),
    .d1       (d1),
    .sel      (sel),
    .y        (y),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_src  (out_src),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  // Model of the downstream select mux.
  assign y = (sel == 2'b00) ? d0 : (sel == 2'b01) ? d1 : '0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: each output handshake pops one expected result.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL result_unexpected: got src=%0d data=%0h, expected none", out_src, out_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({out_src, out_data} !== mon_exp) begin
          fails++;
          $display("FAIL result: got src=%0d data=%0h, expected src=%0d data=%0h",
                   out_src, out_data, mon_exp[N], mon_exp[N-1:0]);
        end else begin
          $display("[TB] result src=%0d data=%0h", out_src, out_data);
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    rst_n     = 1'b0;
    in0_valid = 1'b0;
    in0_data  = '0;
    in1_valid = 1'b0;
    in1_data  = '0;
    out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // 1. Reset state.
    check("rst_in0_ready", in0_ready, 1);
    check("rst_in1_ready", in1_ready, 1);
    check("rst_sel", sel, 2'b10);
    check("rst_out_valid", out_valid, 0);
    check("rst_cnt0", cnt0, 0);
    check("rst_cnt1", cnt1, 0);
    check("rst_out_data", out_data, 0);

    // 2. Single word from source 0.
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 2'b11;
    exp_q.push_back({1'b0, 2'b11});
    step();                               // edge k: accept
    in0_valid = 1'b0;
    check("t2_in0_ready_k", in0_ready, 0);
    check("t2_sel_k", sel, 2'b10);
    check("t2_d0", d0, 2'b11);
    step();                               // edge k+1: SEL
    check("t2_sel_k1", sel, 2'b00);
    check("t2_valid_k1", out_valid, 0);
    step();                               // edge k+2: capture
    check("t2_valid_k2", out_valid, 1);
    check("t2_data_k2", out_data, 2'b11);
    check("t2_src_k2", out_src, 0);
    check("t2_in0_ready_k2", in0_ready, 1);
    check("t2_sel_k2", sel, 2'b10);
    check("t2_cnt0", cnt0, 1);
    step();
    check("t2_valid_k3", out_valid, 0);

    // 3. Tie after reset: source 0 first, then source 1.
    do_reset();
    out_ready = 1'b1;
    in0_valid = 1'b1;
    in0_data  = 2'b01;
    in1_valid = 1'b1;
    in1_data  = 2'b10;
    exp_q.push_back({1'b0, 2'b01});
    exp_q.push_back({1'b1, 2'b10});
    step();                               // both accepted
    in0_valid = 1'b0;
    in1_valid = 1'b0;
    check("t3_sel0", sel, 2'b10);
    step();
    check("t3_sel1", sel, 2'b00);
    step();
    check("t3_sel2", sel, 2'b10);
    check("t3_data_a", out_data, 2'b01);
    check("t3_src_a", out_src, 0);
    step();
    check("t3_sel3", sel, 2'b01);
    check("t3_valid_gap", out_valid, 0);
    step();
    check("t3_sel4", sel, 2'b10);
    check("t3_data_b", out_data, 2'b10);
    check("t3_src_b", out_src, 1);
    step();
    check("t3_idle_valid", out_valid, 0);

    // 4. Backpressure with both buffers full; source 1 was granted last.
    out_ready = 1'b0;
    in0_valid = 1'b1;
    in0_data  = 2'b10;
    in1_valid = 1'b1;
    in1_data  = 2'b01;
    exp_q.push_back({1'b0, 2'b10});
    exp_q.push_back({1'b1, 2'b01});
    exp_q.push_back({1'b0, 2'b00});
    step();                               // edge k: both accepted
    in1_valid = 1'b0;
    in0_data  = 2'b00;                    // second word waits for release
    check("t4_in1_ready_k", in1_ready, 0);
    step();
    check("t4_sel_k1", sel, 2'b00);
    step();
    check("t4_valid_k2", out_valid, 1);
    check("t4_sel_k2", sel, 2'b10);
    step();                               // refill of source 0
    in0_valid = 1'b0;
    check("t4_in0_refilled", in0_ready, 0);
    for (int i = 0; i < 5; i++) begin
      check("t4_bp_valid", out_valid, 1);
      check("t4_bp_data", out_data, 2'b10);
      check("t4_bp_sel", sel, 2'b10);
      check("t4_bp_in1_ready", in1_ready, 0);
      step();
    end
    out_ready = 1'b1;
    step();
    check("t4_next_sel", sel, 2'b01);
    check("t4_next_valid", out_valid, 0);
    step();
    check("t4_out_src1", out_src, 1);
    check("t4_out_data1", out_data, 2'b01);
    step();
    check("t4_third_sel", sel, 2'b00);
    step();
    check("t4_out_src0", out_src, 0);
    check("t4_out_data0", out_data, 2'b00);
    step();
    check("t4_end_valid", out_valid, 0);
    check("t4_end_sel", sel, 2'b10);

    // 5. Counter saturation: 300 grants to source 0.
    do_reset();
    check("t5_cnt0_start", cnt0, 0);
    out_ready = 1'b1;
    in0_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 2000 && acc < 300; c++) begin
      in0_data = acc[1:0];
      if (in0_ready) begin
        exp_q.push_back({1'b0, acc[1:0]});
        acc++;
      end
      step();
    end
    in0_valid = 1'b0;
    check("t5_accepts", acc, 300);
    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    check("t5_drained", exp_q.size(), 0);
    step();
    step();
    check("t5_cnt0_sat", cnt0, 255);
    check("t5_cnt1", cnt1, 0);

    // 6. Reset in the middle of SEL, no clock edge needed.
    in1_valid = 1'b1;
    in1_data  = 2'b10;
    step();
    in1_valid = 1'b0;
    step();
    check("t6_sel_before", sel, 2'b01);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_sel", sel, 2'b10);
    check("t6_valid", out_valid, 0);
    check("t6_in0_ready", in0_ready, 1);
    check("t6_in1_ready", in1_ready, 1);
    check("t6_cnt0", cnt0, 0);
    check("t6_d1", d1, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    step();
    check("t6_after_sel", sel, 2'b10);
    check("t6_after_valid", out_valid, 0);
    check("queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/arb2_mux_sel.md
Name: arb2_mux_sel

Overview:
- Two-source arbitration and sequencing stage that sits directly upstream of the team's 2:1 select mux (2-bit select: 00 selects d0, 01 selects d1, any other code gives zero).
- Buffers one word from each of two valid/ready producers and drives them onto the mux d0/d1 inputs.
- Issues a registered select code using round-robin priority.
- Captures the mux result y into a registered valid/ready output.

Parameters:
- n, 2, data width; must equal the mux width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in0_valid  in  1  source 0 has data.
- in0_ready  out  1  source 0 buffer empty.
- in0_data  in  n  source 0 word.
- in1_valid  in  1  source 1 has data.
- in1_ready  out  1  source 1 buffer empty.
- in1_data  in  n  source 1 word.
- d0  out  n  buffered source 0 word; feeds mux d0.
- d1  out  n  buffered source 1 word; feeds mux d1.
- sel  out  2  registered select code; feeds mux sel.
- y  in  n  mux output (combinational from d0/d1/sel).
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_data  out  n  captured result.
- out_src  out  1  source of out_data (0 or 1).
- cnt0  out  8  grants issued to source 0, saturating.
- cnt1  out  8  grants issued to source 1, saturating.

Behaviour:
- Reset (rst_n low, async):
  - State IDLE.
  - buf0_full = 0, buf1_full = 0.
  - d0 = d1 = 0, out_data = 0, out_valid = 0, out_src = 0, cnt0 = cnt1 = 0.
  - sel = 2'b10, so the mux outputs 0.
  - last = 1, so source 0 wins the first tie.
- Input buffers, one entry per source:
  - inN_ready = ~bufN_full, driven combinationally from the register.
  - On an edge where inN_valid & inN_ready: dN <= inN_data and bufN_full <= 1.
  - dN holds its value until the next accept; it is never cleared on release.
- Arbitration, evaluated in IDLE, and in HOLD when out_ready = 1:
  - Only one buffer full: pick that source.
  - Both full: pick ~last.
  - Neither full: no grant.
- FSM states: IDLE, SEL, HOLD.
  - IDLE: sel = 2'b10. On a grant to source g: sel <= {1'b0, g}, go to SEL. Otherwise stay.
  - SEL, exactly one cycle: sel holds 00 or 01 and the mux settles combinationally. At the closing edge:
    - out_data <= y, out_src <= g, out_valid <= 1.
    - buf_g_full <= 0, last <= g, cnt_g <= cnt_g + 1, saturating at 255.
    - sel <= 2'b10; go to HOLD.
  - HOLD: out_valid = 1; out_data and out_src are stable.
    - out_ready = 0: stay.
    - out_ready = 1 with a grant available: out_valid <= 0, sel <= {0, g}, go to SEL (back-to-back path).
    - out_ready = 1 with no grant: out_valid <= 0, go to IDLE.
- Latency:
  - Accept at edge k, with the FSM idle and no competition: SEL after edge k+1, out_valid = 1 after edge k+2.
  - Sustained throughput with out_ready tied high is one result per 2 cycles.
- sel never takes 2'b11.
- sel is 2'b10 in every state except SEL.
- A buffer released at the SEL closing edge shows ready = 1 in the following cycle; it cannot accept on the release edge itself.
- Both sources valid every cycle: grants strictly alternate.
- out_ready asserted while out_valid = 0 has no effect.
- Reset asserted mid-operation (any state): all registers go immediately to their reset values and any held or buffered data is discarded. Deassertion is assumed synchronous to clk, provided by the system.

Test Plan:
1. Reset check: hold rst_n = 0 and then release -> in0_ready = in1_ready = 1, sel = 10, out_valid = 0, cnt0 = cnt1 = 0.
2. Single word: n = 2, in0_data = 2'b11 accepted at edge k, out_ready = 1 -> sel = 00 during cycle k+1..k+2; out_valid = 1, out_data = 11, out_src = 0 after edge k+2; in0_ready returns to 1 after edge k+2.
3. Tie after reset: in0 = 01 and in1 = 10 accepted on the same edge, out_ready = 1 -> outputs 01 (src 0) then 10 (src 1), two cycles apart; sel sequence 10, 00, 10, 01, 10.
4. Backpressure: out_ready = 0 for 5 cycles with both buffers full -> out_valid stays 1, out_data unchanged, sel = 10, in1_ready = 0; after out_ready = 1 the next grant goes to the other source.
5. Saturation: 300 grants to source 0 -> cnt0 = 255, cnt1 = 0.
6. Mid-SEL reset: assert rst_n = 0 while sel = 01 -> sel = 10, out_valid = 0, both buffers empty with no clock edge required.
